// File: rtl/lsu_initiator_pkg.sv
// Shared opcode constants and helpers for the MEM-stage load/store initiator.
// LSU_ALIGN_CHECK_EN enables misalignment trapping in lsu_initiator.
package lsu_initiator_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op,
                                           input logic [1:0] lo);
        logic m;
        m = 1'b0;
        if (op == OP_LW || op == OP_SW)
            m = (lo != 2'b00);
        else if (op == OP_LH || op == OP_LHU || op == OP_SH)
            m = lo[0];
        return m;
    endfunction

endpackage

// File: rtl/lsu_initiator_lane_unit.sv
// Little-endian lane extract/extend for loads and lane merge for stores.
// Purely combinational; shared by the LOAD and WR states.
module lsu_lane_unit
    import lsu_initiator_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [5:0]  op,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        load_val = '0;
        case (op)
            OP_LB:   load_val = {{24{b[7]}}, b};
            OP_LBU:  load_val = {24'h0, b};
            OP_LH:   load_val = {{16{h[15]}}, h};
            OP_LHU:  load_val = {16'h0, h};
            OP_LW:   load_val = rdata;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        store_word = rdata;
        case (op)
            OP_SW:   store_word = wdata;
            OP_SB:   store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            OP_SH:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// MEM-stage load/store initiator: one command at a time, RMW for sb/sh.
// Define LSU_ALIGN_CHECK_EN to trap misaligned lw/sw/lh/lhu/sh.
module lsu_initiator
    import lsu_initiator_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] pc,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              exc_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_e;

    state_e state, state_nx;

    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;
    logic              accept;
    logic              mis;

    assign accept = (state == S_IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
    assign mis = is_misaligned(op, addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (mis)
                        state_nx = S_RESP;
                    else if (is_load(op))
                        state_nx = S_LOAD;
                    else if (op == OP_SW)
                        state_nx = S_WR;
                    else if (op == OP_SB || op == OP_SH)
                        state_nx = S_RMW_RD;
                    else
                        state_nx = S_RESP;
                end
            end
            S_LOAD:   state_nx = S_RESP;
            S_RMW_RD: state_nx = S_WR;
            S_WR:     state_nx = S_RESP;
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Loads extract from the live read word; stores merge into the captured one.
    assign rd_word = (state == S_LOAD) ? mem_rdata : merge_q;

    lsu_lane_unit u_lane (
        .lane       (addr_q[1:0]),
        .op         (op_q),
        .rdata      (rd_word),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            merge_q   <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
            end
            if (state == S_RMW_RD)
                merge_q <= mem_rdata;
            if (state == S_LOAD)
                resp_data <= load_val;
            else if (state == S_WR)
                resp_data <= '0;
            else if (accept && state_nx == S_RESP)
                resp_data <= '0;
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic exc_q;

    always_ff @(posedge clk) begin
        if (rst)
            exc_q <= 1'b0;
        else if (accept)
            exc_q <= mis;
    end

    assign exc_misaligned = exc_q;
`else
    assign exc_misaligned = 1'b0;
`endif

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_pc     = pc_q;
    assign mem_we     = (state == S_WR) && !rst;
    assign mem_wdata  = (state == S_WR) ? store_word : '0;

endmodule

// File: tb/tb_lsu_initiator.sv
// Randomized bench for lsu_initiator against a byte-arithmetic memory model.
// Honours LSU_ALIGN_CHECK_EN when deciding misaligned expectations.
module tb_lsu_initiator;
    import lsu_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        exc_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    lsu_initiator dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .op             (op),
        .addr           (addr),
        .wdata          (wdata),
        .pc             (pc),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .exc_misaligned (exc_misaligned),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_pc         (mem_pc),
        .mem_rdata      (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk)
        if (mem_we)
            mem[mem_addr[7:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit tb_mis(input logic [5:0] o, input logic [31:0] a);
        if (o == OP_LW || o == OP_SW)
            return a % 4 != 0;
        if (o == OP_LH || o == OP_LHU || o == OP_SH)
            return a % 2 != 0;
        return 0;
    endfunction

    function automatic bit trap(input logic [5:0] o, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        return tb_mis(o, a);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] o,
                                             input logic [31:0] a);
        logic [31:0] w, bv, hv;
        w  = ref_mem[(a % 256) / 4];
        bv = (w >> (8 * (a % 4))) & 32'hFF;
        hv = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (o)
            OP_LB:   return (bv >= 128) ? (bv | 32'hFFFFFF00) : bv;
            OP_LBU:  return bv;
            OP_LH:   return (hv >= 32768) ? (hv | 32'hFFFF0000) : hv;
            OP_LHU:  return hv;
            OP_LW:   return w;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [5:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] wd);
        logic [31:0] w, m;
        w = ref_mem[(a % 256) / 4];
        if (o == OP_SW)
            return wd;
        if (o == OP_SB) begin
            m = 32'hFF << (8 * (a % 4));
            return (w & ~m) | ((wd & 32'hFF) << (8 * (a % 4)));
        end
        m = 32'hFFFF << (16 * ((a / 2) % 2));
        return (w & ~m) | ((wd & 32'hFFFF) << (16 * ((a / 2) % 2)));
    endfunction

    task automatic do_op(input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p,
                         output logic [31:0] got);
        int cyc, we_n, e_lat, idx;
        bit done, st, ld;
        logic [31:0] wa, wdw, e_resp;
        idx = (a % 256) / 4;
        ld  = is_load(o) && !trap(o, a);
        st  = (o == OP_SW || o == OP_SB || o == OP_SH) && !trap(o, a);
        e_resp = ld ? ref_load(o, a) : 32'h0;
        if (trap(o, a))            e_lat = 1;
        else if (ld)               e_lat = 2;
        else if (o == OP_SW)       e_lat = 2;
        else if (st)               e_lat = 3;
        else                       e_lat = 1;
        if (st)
            ref_mem[idx] = ref_store(o, a, wd);
        @(negedge clk);
        chk("ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        op = o; addr = a; wdata = wd; pc = p;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op = 6'($urandom); addr = $urandom; wdata = $urandom; pc = $urandom;
        cyc = 0; we_n = 0; done = 0; wa = '0; wdw = '0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            chk("ready_busy", {31'h0, req_ready}, 32'h0);
            if (mem_we) begin
                we_n++;
                wa = mem_addr;
                wdw = mem_wdata;
            end
            if (resp_valid)
                done = 1;
        end
        got = resp_data;
        chk("latency", cyc, e_lat);
        chk("resp_data", resp_data, e_resp);
        chk("exc", {31'h0, exc_misaligned}, {31'h0, trap(o, a)});
        chk("we_pulses", we_n, st ? 1 : 0);
        chk("mem_pc", mem_pc, p);
        if (st) begin
            chk("we_addr", wa, {a[31:2], 2'b00});
            chk("we_data", wdw, ref_mem[idx]);
        end
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
        chk("resp_hold", resp_data, e_resp);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic reset_during(input logic [5:0] o, input logic [31:0] a,
                                input int stall);
        int idx, bad;
        idx = (a % 256) / 4;
        @(negedge clk);
        req_valid = 1'b1;
        op = o; addr = a; wdata = $urandom; pc = $urandom;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (stall) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("we_gated", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_we)
                bad++;
        end
        chk("rst_quiet", bad, 0);
        chk("rst_mem", mem[idx], ref_mem[idx]);
    endtask

    logic [5:0] ops [0:9];
    logic [31:0] r;

    initial begin
        ops[0] = OP_LB;  ops[1] = OP_LH;  ops[2] = OP_LW;
        ops[3] = OP_LBU; ops[4] = OP_LHU; ops[5] = OP_SB;
        ops[6] = OP_SH;  ops[7] = OP_SW;  ops[8] = 6'h00;
        ops[9] = 6'h0f;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]  = 32'h8899AABB; ref_mem[4]  = 32'h8899AABB;
        mem[8]  = 32'h80017FFF; ref_mem[8]  = 32'h80017FFF;
        mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_exc", {31'h0, exc_misaligned}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_pc", mem_pc, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        do_op(OP_LB, 32'h11, 32'h0, 32'h100, r);
        chk("lb_0x11", r, 32'hFFFFFFAA);
        do_op(OP_LBU, 32'h11, 32'h0, 32'h104, r);
        chk("lbu_0x11", r, 32'h000000AA);
        do_op(OP_LH, 32'h22, 32'h0, 32'h108, r);
        chk("lh_0x22", r, 32'hFFFF8001);
        do_op(OP_LHU, 32'h20, 32'h0, 32'h10c, r);
        chk("lhu_0x20", r, 32'h00007FFF);
        do_op(OP_SW, 32'h30, 32'hDEADBEEF, 32'h110, r);
        do_op(OP_LW, 32'h30, 32'h0, 32'h114, r);
        chk("lw_0x30", r, 32'hDEADBEEF);
        do_op(OP_SB, 32'h42, 32'h000000AB, 32'h118, r);
        chk("sb_0x42", mem[16], 32'h11AB3344);
        do_op(OP_LW, 32'h13, 32'h0, 32'h11c, r);
`ifdef LSU_ALIGN_CHECK_EN
        chk("lw_0x13", r, 32'h0);
`else
        chk("lw_0x13", r, 32'h8899AABB);
`endif
        do_op(6'h0f, 32'h44, 32'h0, 32'h120, r);

        reset_during(OP_SH, 32'h24, 1);
        reset_during(OP_SB, 32'h25, 2);

        for (int i = 0; i < 60; i++)
            do_op(ops[$urandom_range(0, 9)], $urandom_range(0, 255),
                  $urandom, $urandom, r);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
